config_loader: RTL

Serial configuration loader for the fabric. It receives a framed bitstream one bit per clock and writes each frame's payload into the LUT configuration word (33 bits) of a logic tile or the 16-bit crossbar word of a 4x4 switch box. It drives the flattened configuration buses that feed the tile and switch-box instances. It is the writer side of the configuration memories those blocks only read.

---
 rtl/config_loader_if.sv | 25 ++
 rtl/config_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Bus bundle between the configuration bitstream source and config_loader.
// The slave modport is the loader side; the master modport is the bitstream driver side.
interface config_loader_if #(
    parameter int N_TILES  = 4,
    parameter int N_SWITCH = 4
);
    logic                    cfg_data;
    logic                    cfg_valid;
    logic [33*N_TILES-1:0]   tile_cfg;
    logic [16*N_SWITCH-1:0]  sb_cfg;
    logic                    cfg_busy;
    logic                    cfg_done;
    logic                    cfg_error;
    logic [7:0]              err_count;

    modport slave (
        input  cfg_data, cfg_valid,
        output tile_cfg, sb_cfg, cfg_busy, cfg_done, cfg_error, err_count
    );

    modport master (
        output cfg_data, cfg_valid,
        input  tile_cfg, sb_cfg, cfg_busy, cfg_done, cfg_error, err_count
    );
endinterface

// File: rtl/config_loader.sv
// Serial configuration loader: framed bitstream -> tile LUT words and switch-box crossbar words.
// Optional feature macro: CFG_PARITY_EN adds a checked even-parity bit after every payload.
module config_loader #(
    parameter int N_TILES  = 4,
    parameter int N_SWITCH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    config_loader_if.slave cfg
);
    typedef enum logic [2:0] {
        S_HUNT,
        S_HDR,
        S_PAY,
        S_PAR,
        S_COMMIT
    } state_t;

`ifdef CFG_PARITY_EN
    localparam state_t S_AFTER_PAY = S_PAR;
`else
    localparam state_t S_AFTER_PAY = S_COMMIT;
`endif

    localparam logic [4:0] NT5 = 5'(N_TILES);
    localparam logic [4:0] NS5 = 5'(N_SWITCH);

    state_t r_state, w_state_nx;

    logic [7:0]              r_win;
    logic [4:0]              r_hdr;
    logic [5:0]              r_cnt;
    logic [32:0]             r_shadow;
    logic                    r_bad;
    logic                    r_par;
    logic [33*N_TILES-1:0]   r_tile_cfg;
    logic [16*N_SWITCH-1:0]  r_sb_cfg;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [7:0]              r_err_cnt;

    logic       w_acc;
    logic       w_bit;
    logic [7:0] w_win_nx;
    logic [4:0] w_hdr_nx;
    logic       w_hdr_last;
    logic       w_pay_last;
    logic       w_is_end;
    logic       w_oor;

    assign w_acc      = cfg.cfg_valid;
    assign w_bit      = cfg.cfg_data;
    assign w_win_nx   = {r_win[6:0], w_bit};
    assign w_hdr_nx   = {r_hdr[3:0], w_bit};
    assign w_hdr_last = (r_cnt == 6'd4);
    assign w_pay_last = r_hdr[4] ? (r_cnt == 6'd15) : (r_cnt == 6'd32);
    assign w_is_end   = (w_hdr_nx == 5'b11111);
    // END is decoded before the range check, so a switch index of 15 never counts as out of range.
    assign w_oor      = w_hdr_nx[4] ? ({1'b0, w_hdr_nx[3:0]} >= NS5)
                                    : ({1'b0, w_hdr_nx[3:0]} >= NT5);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_HUNT;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_HUNT:   if (w_acc && (w_win_nx == 8'hA5)) w_state_nx = S_HDR;
            S_HDR:    if (w_acc && w_hdr_last) w_state_nx = w_is_end ? S_HUNT : S_PAY;
            S_PAY:    if (w_acc && w_pay_last) w_state_nx = S_AFTER_PAY;
            S_PAR:    if (w_acc) w_state_nx = S_COMMIT;
            S_COMMIT: w_state_nx = S_HUNT;
            default:  w_state_nx = S_HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_win      <= '0;
            r_hdr      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_bad      <= 1'b0;
            r_par      <= 1'b0;
            r_tile_cfg <= '0;
            r_sb_cfg   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (w_acc) begin
                        if (w_win_nx == 8'hA5) begin
                            r_win    <= '0;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            r_cnt    <= '0;
                            r_hdr    <= '0;
                            r_shadow <= '0;
                            r_bad    <= 1'b0;
                        end else begin
                            r_win <= w_win_nx;
                        end
                    end
                end
                S_HDR: begin
                    if (w_acc) begin
                        r_hdr <= w_hdr_nx;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_hdr_last) begin
                            r_cnt <= '0;
                            r_par <= ^w_hdr_nx;
                            r_bad <= w_oor;
                            if (w_is_end) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
                        end
                    end
                end
                S_PAY: begin
                    // Payload arrives LSB first, so the bit counter is also the bit position.
                    if (w_acc) begin
                        r_shadow[r_cnt] <= w_bit;
                        r_par           <= r_par ^ w_bit;
                        r_cnt           <= r_cnt + 6'd1;
                    end
                end
                S_PAR: begin
                    if (w_acc && (r_par != w_bit)) r_bad <= 1'b1;
                end
                S_COMMIT: begin
                    r_busy <= 1'b0;
                    r_win  <= '0;
                    if (r_bad) begin
                        r_error <= 1'b1;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else begin
                        for (int i = 0; i < N_TILES; i++)
                            if (!r_hdr[4] && (r_hdr[3:0] == 4'(i)))
                                r_tile_cfg[33*i +: 33] <= r_shadow;
                        for (int j = 0; j < N_SWITCH; j++)
                            if (r_hdr[4] && (r_hdr[3:0] == 4'(j)))
                                r_sb_cfg[16*j +: 16] <= r_shadow[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg.tile_cfg  = r_tile_cfg;
    assign cfg.sb_cfg    = r_sb_cfg;
    assign cfg.cfg_busy  = r_busy;
    assign cfg.cfg_done  = r_done;
    assign cfg.cfg_error = r_error;
    assign cfg.err_count = r_err_cnt;
endmodule
